// File: rtl/cr2_jtag_tap_if.sv
// Pin bundle between an external JTAG initiator and the CoolRunner-II TAP responder.
// slave = device-side TAP, master = initiator / bench side.
interface cr2_jtag_tap_if #(
  parameter int SAMPLE_WIDTH = 32
);
  logic                    TMS;
  logic                    TDI;
  logic                    TDO;
  logic                    TDO_OE;
  logic [SAMPLE_WIDTH-1:0] SAMPLE_IN;
  logic [SAMPLE_WIDTH-1:0] SAMPLE_OUT;
  logic                    UPDATE_STB;
  logic [3:0]              TAP_STATE;

  modport slave (
    input  TMS, TDI, SAMPLE_IN,
    output TDO, TDO_OE, SAMPLE_OUT, UPDATE_STB, TAP_STATE
  );

  modport master (
    output TMS, TDI, SAMPLE_IN,
    input  TDO, TDO_OE, SAMPLE_OUT, UPDATE_STB, TAP_STATE
  );
endinterface

// File: rtl/cr2_jtag_tap.sv
// IEEE 1149.1 TAP responder: 16-state controller, IR plus BYPASS/IDCODE/SAMPLE data registers.
// TDO is combinational from state and shift LSB; SAMPLE_OUT/UPDATE_STB register on entry to Update-DR.
module cr2_jtag_tap #(
  parameter logic [31:0]          IDCODE       = 32'h06E1C093,
  parameter int                   IR_WIDTH     = 8,
  parameter int                   SAMPLE_WIDTH = 32,
  parameter logic [IR_WIDTH-1:0]  OP_IDCODE    = IR_WIDTH'(8'h01),
  parameter logic [IR_WIDTH-1:0]  OP_SAMPLE    = IR_WIDTH'(8'h03),
  parameter logic [IR_WIDTH-1:0]  OP_BYPASS    = IR_WIDTH'(8'hFF)
) (
  input  logic          C,
  input  logic          CLR_N,
  cr2_jtag_tap_if.slave bus
);

  localparam logic [3:0] ST_TLR     = 4'd0;
  localparam logic [3:0] ST_RTI     = 4'd1;
  localparam logic [3:0] ST_SELDR   = 4'd2;
  localparam logic [3:0] ST_CAPDR   = 4'd3;
  localparam logic [3:0] ST_SHDR    = 4'd4;
  localparam logic [3:0] ST_EX1DR   = 4'd5;
  localparam logic [3:0] ST_PAUSEDR = 4'd6;
  localparam logic [3:0] ST_EX2DR   = 4'd7;
  localparam logic [3:0] ST_UPDDR   = 4'd8;
  localparam logic [3:0] ST_SELIR   = 4'd9;
  localparam logic [3:0] ST_CAPIR   = 4'd10;
  localparam logic [3:0] ST_SHIR    = 4'd11;
  localparam logic [3:0] ST_EX1IR   = 4'd12;
  localparam logic [3:0] ST_PAUSEIR = 4'd13;
  localparam logic [3:0] ST_EX2IR   = 4'd14;
  localparam logic [3:0] ST_UPDIR   = 4'd15;

  localparam logic [1:0] DR_BYP = 2'd0;
  localparam logic [1:0] DR_ID  = 2'd1;
  localparam logic [1:0] DR_SMP = 2'd2;

  localparam logic [IR_WIDTH-1:0] IR_CAPTURE = IR_WIDTH'(2'b01);

  logic [3:0]              state;
  logic [3:0]              state_nxt;
  logic [IR_WIDTH-1:0]     ir;
  logic [IR_WIDTH-1:0]     ir_sh;
  logic [31:0]             id_sh;
  logic                    byp_sh;
  logic [SAMPLE_WIDTH-1:0] smp_sh;
  logic [SAMPLE_WIDTH-1:0] sample_out;
  logic                    update_stb;
  logic [1:0]              dr_sel;
  logic                    tdo;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_TLR:     state_nxt = bus.TMS ? ST_TLR     : ST_RTI;
      ST_RTI:     state_nxt = bus.TMS ? ST_SELDR   : ST_RTI;
      ST_SELDR:   state_nxt = bus.TMS ? ST_SELIR   : ST_CAPDR;
      ST_CAPDR:   state_nxt = bus.TMS ? ST_EX1DR   : ST_SHDR;
      ST_SHDR:    state_nxt = bus.TMS ? ST_EX1DR   : ST_SHDR;
      ST_EX1DR:   state_nxt = bus.TMS ? ST_UPDDR   : ST_PAUSEDR;
      ST_PAUSEDR: state_nxt = bus.TMS ? ST_EX2DR   : ST_PAUSEDR;
      ST_EX2DR:   state_nxt = bus.TMS ? ST_UPDDR   : ST_SHDR;
      ST_UPDDR:   state_nxt = bus.TMS ? ST_SELDR   : ST_RTI;
      ST_SELIR:   state_nxt = bus.TMS ? ST_TLR     : ST_CAPIR;
      ST_CAPIR:   state_nxt = bus.TMS ? ST_EX1IR   : ST_SHIR;
      ST_SHIR:    state_nxt = bus.TMS ? ST_EX1IR   : ST_SHIR;
      ST_EX1IR:   state_nxt = bus.TMS ? ST_UPDIR   : ST_PAUSEIR;
      ST_PAUSEIR: state_nxt = bus.TMS ? ST_EX2IR   : ST_PAUSEIR;
      ST_EX2IR:   state_nxt = bus.TMS ? ST_UPDIR   : ST_SHIR;
      ST_UPDIR:   state_nxt = bus.TMS ? ST_SELDR   : ST_RTI;
      default:    state_nxt = ST_TLR;
    endcase
  end

  always_ff @(posedge C or negedge CLR_N) begin
    if (!CLR_N) state <= ST_TLR;
    else        state <= state_nxt;
  end

  // Unrecognised opcodes fall through to BYPASS.
  always_comb begin
    dr_sel = DR_BYP;
    case (ir)
      OP_IDCODE: dr_sel = DR_ID;
      OP_SAMPLE: dr_sel = DR_SMP;
      OP_BYPASS: dr_sel = DR_BYP;
      default:   dr_sel = DR_BYP;
    endcase
  end

  always_ff @(posedge C or negedge CLR_N) begin
    if (!CLR_N) begin
      ir    <= OP_IDCODE;
      ir_sh <= '0;
    end else begin
      case (state)
        ST_TLR:   ir    <= OP_IDCODE;
        ST_CAPIR: ir_sh <= IR_CAPTURE;
        ST_SHIR:  ir_sh <= {bus.TDI, ir_sh[IR_WIDTH-1:1]};
        ST_UPDIR: ir    <= ir_sh;
        default:  ;
      endcase
    end
  end

  always_ff @(posedge C or negedge CLR_N) begin
    if (!CLR_N) begin
      id_sh  <= '0;
      byp_sh <= 1'b0;
      smp_sh <= '0;
    end else if (state == ST_CAPDR) begin
      case (dr_sel)
        DR_ID:   id_sh  <= IDCODE;
        DR_SMP:  smp_sh <= bus.SAMPLE_IN;
        default: byp_sh <= 1'b0;
      endcase
    end else if (state == ST_SHDR) begin
      // Shift form tolerates SAMPLE_WIDTH == 1 where a part-select would not.
      case (dr_sel)
        DR_ID:   id_sh  <= {bus.TDI, id_sh[31:1]};
        DR_SMP:  smp_sh <= (smp_sh >> 1) | (SAMPLE_WIDTH'(bus.TDI) << (SAMPLE_WIDTH - 1));
        default: byp_sh <= bus.TDI;
      endcase
    end
  end

  // Written on the edge entering Update-DR so the strobe spans exactly that state.
  always_ff @(posedge C or negedge CLR_N) begin
    if (!CLR_N) begin
      sample_out <= '0;
      update_stb <= 1'b0;
    end else if (state_nxt == ST_UPDDR && dr_sel == DR_SMP) begin
      sample_out <= smp_sh;
      update_stb <= 1'b1;
    end else begin
      update_stb <= 1'b0;
    end
  end

  always_comb begin
    tdo = 1'b0;
    if (state == ST_SHIR) begin
      tdo = ir_sh[0];
    end else if (state == ST_SHDR) begin
      case (dr_sel)
        DR_ID:   tdo = id_sh[0];
        DR_SMP:  tdo = smp_sh[0];
        default: tdo = byp_sh;
      endcase
    end
  end

  assign bus.TDO        = tdo;
  assign bus.TDO_OE     = (state == ST_SHDR) || (state == ST_SHIR);
  assign bus.SAMPLE_OUT = sample_out;
  assign bus.UPDATE_STB = update_stb;
  assign bus.TAP_STATE  = state;

endmodule

// File: tb/tb_cr2_jtag_tap.sv
// Bench for cr2_jtag_tap: directed scan scenarios plus a randomized TMS/TDI walk, all
// checked each cycle against a queue-based model of the TAP driven by a transition table.
module tb_cr2_jtag_tap;

  localparam logic [31:0] IDC = 32'h06E1C093;

  logic C;
  logic CLR_N;
  cr2_jtag_tap_if #(.SAMPLE_WIDTH(32)) bus ();

  cr2_jtag_tap dut (
    .C     (C),
    .CLR_N (CLR_N),
    .bus   (bus)
  );

  initial C = 1'b0;
  always #5 C = ~C;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: next state by table, shift registers as bit queues (front = TDO side).
  int nxt0 [16] = '{1, 1, 3, 4, 4, 6, 6, 4, 1, 10, 11, 11, 13, 13, 11, 1};
  int nxt1 [16] = '{0, 2, 9, 5, 5, 8, 7, 8, 2, 0, 12, 12, 15, 14, 15, 2};
  int          m_state;
  int          m_sel;          // 0 bypass, 1 idcode, 2 sample
  bit          irq[$];
  bit          drq[$];
  logic [31:0] m_sout;
  bit          m_stb;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fill(input logic [31:0] v, input int n, inout bit q[$]);
    q.delete();
    for (int i = 0; i < n; i++) q.push_back(v[i]);
  endtask

  task automatic model_reset();
    m_state = 0;
    m_sel   = 1;
    m_sout  = '0;
    m_stb   = 1'b0;
    fill(32'h0, 8, irq);
    fill(32'h0, 32, drq);
  endtask

  task automatic model_step(input bit tms, input bit tdi);
    logic [7:0]  v;
    logic [31:0] s;
    case (m_state)
      0:  m_sel = 1;
      10: fill(32'h1, 8, irq);
      11: begin void'(irq.pop_front()); irq.push_back(tdi); end
      15: begin
        for (int i = 0; i < 8; i++) v[i] = irq[i];
        m_sel = (v == 8'h01) ? 1 : (v == 8'h03) ? 2 : 0;
      end
      3:  begin
        if (m_sel == 1)      fill(IDC, 32, drq);
        else if (m_sel == 2) fill(bus.SAMPLE_IN, 32, drq);
        else                 fill(32'h0, 1, drq);
      end
      4:  begin void'(drq.pop_front()); drq.push_back(tdi); end
      default: ;
    endcase
    m_state = tms ? nxt1[m_state] : nxt0[m_state];
    m_stb = 1'b0;
    if (m_state == 8 && m_sel == 2) begin
      for (int i = 0; i < 32; i++) s[i] = drq[i];
      m_sout = s;
      m_stb  = 1'b1;
    end
  endtask

  task automatic check_all();
    bit e_tdo;
    e_tdo = (m_state == 4) ? drq[0] : (m_state == 11) ? irq[0] : 1'b0;
    chk("tap_state",  bus.TAP_STATE,  m_state);
    chk("tdo",        bus.TDO,        e_tdo);
    chk("tdo_oe",     bus.TDO_OE,     (m_state == 4 || m_state == 11));
    chk("sample_out", bus.SAMPLE_OUT, m_sout);
    chk("update_stb", bus.UPDATE_STB, m_stb);
  endtask

  task automatic tick(input bit tms, input bit tdi, output bit tdo_pre);
    bus.TMS = tms;
    bus.TDI = tdi;
    tdo_pre = bus.TDO;
    @(posedge C);
    if (CLR_N) model_step(tms, tdi);
    @(negedge C);
    check_all();
  endtask

  task automatic go(input bit tms);
    bit d;
    tick(tms, 1'b0, d);
  endtask

  task automatic async_reset();
    #2 CLR_N = 1'b0;
    #1 model_reset();
    chk("rst_state_now", bus.TAP_STATE, 4'd0);
    chk("rst_oe_now",    bus.TDO_OE,    1'b0);
    check_all();
    @(negedge C);
    check_all();
    CLR_N = 1'b1;
  endtask

  // From RTI: load an 8-bit opcode, return the TDO stream seen during Shift-IR, end in RTI.
  task automatic load_ir(input logic [7:0] op, output logic [7:0] tdo_bits);
    bit d;
    go(1); go(1); go(0); go(0);
    for (int i = 0; i < 8; i++) begin
      tick(i == 7, op[i], d);
      tdo_bits[i] = d;
    end
    go(1); go(0);
  endtask

  // From RTI: scan n DR bits, optionally pausing after pause_at bits; ends in Update-DR.
  task automatic dr_scan(input int n, input logic [63:0] din, input int pause_at,
                         output logic [63:0] dout);
    bit d;
    bit last;
    bit pz;
    dout = '0;
    go(1); go(0); go(0);
    for (int i = 0; i < n; i++) begin
      last = (i == n - 1);
      pz   = (pause_at > 0) && (i == pause_at - 1) && !last;
      tick(last || pz, din[i], d);
      dout[i] = d;
      if (pz) begin
        go(0);
        repeat (4) go(0);
        chk("pause_oe", bus.TDO_OE, 1'b0);
        go(1); go(0);
      end
    end
    go(1);
  endtask

  logic [7:0]  irb;
  logic [63:0] dout;
  bit          dummy;

  initial begin
    CLR_N         = 1'b0;
    bus.TMS       = 1'b0;
    bus.TDI       = 1'b0;
    bus.SAMPLE_IN = '0;
    model_reset();
    repeat (2) @(negedge C);
    check_all();
    chk("reset_state", bus.TAP_STATE, 4'd0);
    CLR_N = 1'b1;

    // 1: reset mid Shift-DR, then IDCODE read with the default instruction
    go(0); go(1); go(0); go(0);
    repeat (5) tick(1'b0, 1'($urandom_range(0, 1)), dummy);
    chk("midshift_state", bus.TAP_STATE, 4'd4);
    async_reset();
    go(0);
    dr_scan(32, {$urandom, $urandom}, 0, dout);
    chk("idcode_read", dout[31:0], IDC);
    go(0);

    // 2: IR capture pattern, then BYPASS one-cycle path
    load_ir(8'hFF, irb);
    chk("ir_capture", irb, 8'h01);
    dr_scan(4, 64'b0110, 0, dout);
    chk("bypass_tdo", dout[3:0], 4'b1100);
    chk("bypass_no_stb", bus.UPDATE_STB, 1'b0);
    go(0);

    // 3: SAMPLE capture and update
    load_ir(8'h03, irb);
    bus.SAMPLE_IN = 32'hA5A5_0F0F;
    dr_scan(32, 64'h1234_5678, 0, dout);
    chk("sample_tdo", dout[31:0], 32'hA5A5_0F0F);
    chk("sample_out", bus.SAMPLE_OUT, 32'h1234_5678);
    chk("sample_stb", bus.UPDATE_STB, 1'b1);
    go(0);
    chk("sample_stb_off", bus.UPDATE_STB, 1'b0);

    // 4: same scan split by a Pause
    dr_scan(32, 64'h1234_5678, 10, dout);
    chk("pause_tdo", dout[31:0], 32'hA5A5_0F0F);
    chk("pause_out", bus.SAMPLE_OUT, 32'h1234_5678);
    go(0);

    // 5: unknown opcode behaves as BYPASS
    load_ir(8'h5A, irb);
    bus.SAMPLE_IN = 32'hDEAD_BEEF;
    dr_scan(4, 64'b0110, 0, dout);
    chk("unk_tdo", dout[3:0], 4'b1100);
    chk("unk_stb", bus.UPDATE_STB, 1'b0);
    chk("unk_out", bus.SAMPLE_OUT, 32'h1234_5678);
    go(0);

    // 6: five TMS=1 clocks from ShIR, PauseDR, UpdIR
    go(1); go(1); go(0); go(0);
    repeat (5) go(1);
    chk("tlr_from_shir", bus.TAP_STATE, 4'd0);
    go(0); go(1); go(0); go(0); go(1); go(0);
    chk("in_pausedr", bus.TAP_STATE, 4'd6);
    repeat (5) go(1);
    chk("tlr_from_pausedr", bus.TAP_STATE, 4'd0);
    go(0); go(1); go(1); go(0); go(0);
    for (int i = 0; i < 8; i++) tick(i == 7, 1'b1, dummy);
    go(1);
    chk("in_updir", bus.TAP_STATE, 4'd15);
    repeat (5) go(1);
    chk("tlr_from_updir", bus.TAP_STATE, 4'd0);
    go(0);
    dr_scan(32, 64'h0, 0, dout);
    chk("ir_back_to_idcode", dout[31:0], IDC);
    go(0);

    // Randomized walk: seed an instruction, then free-run TMS/TDI/SAMPLE_IN
    for (int it = 0; it < 40; it++) begin
      logic [7:0] op;
      case ($urandom_range(0, 3))
        0:       op = 8'h01;
        1:       op = 8'h03;
        2:       op = 8'hFF;
        default: op = 8'($urandom);
      endcase
      repeat (5) go(1);
      go(0);
      load_ir(op, irb);
      for (int k = 0; k < 60; k++) begin
        bus.SAMPLE_IN = $urandom;
        if ($urandom_range(0, 149) == 0) async_reset();
        else tick($urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)), dummy);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/cr2_jtag_tap.md
Name: cr2_jtag_tap

Overview:
JTAG TAP responder for the CoolRunner-II flow. It sits on the device side of the programming/boundary-scan port and is driven by an external JTAG initiator. It implements the IEEE 1149.1 16-state TAP controller with an 8-bit instruction register and three data registers: BYPASS, IDCODE and a SAMPLE chain. The SAMPLE chain captures macrocell/IO states and can update a parallel shadow register.

Parameters:
IDCODE, 32'h06E1C093, value loaded into the IDCODE DR at Capture-DR; bit 0 must be 1.
IR_WIDTH, 8, instruction register width; minimum 2.
SAMPLE_WIDTH, 32, length of the SAMPLE data register; minimum 1.
OP_IDCODE, 8'h01, IDCODE opcode.
OP_SAMPLE, 8'h03, SAMPLE opcode.
OP_BYPASS, 8'hFF, BYPASS opcode.

Ports:
C  input  1  TCK; all state changes on posedge.
CLR_N  input  1  asynchronous active-low reset (TRST equivalent).
TMS  input  1  mode select, sampled on posedge C.
TDI  input  1  serial data in, sampled on posedge C.
TDO  output  1  serial data out, combinational from shift-register LSB.
TDO_OE  output  1  high only in Shift-DR or Shift-IR.
SAMPLE_IN  input  SAMPLE_WIDTH  parallel vector captured at Capture-DR under SAMPLE.
SAMPLE_OUT  output  SAMPLE_WIDTH  shadow register written at Update-DR under SAMPLE.
UPDATE_STB  output  1  one-cycle pulse on the cycle SAMPLE_OUT is written.
TAP_STATE  output  4  current TAP state encoding, for debug.

Behaviour:
- Reset: CLR_N low → immediately TAP_STATE=Test-Logic-Reset(0), IR=OP_IDCODE, SAMPLE_OUT=0, UPDATE_STB=0, all shift regs=0, TDO=0, TDO_OE=0. Reset mid-shift aborts the shift with no update.
- TAP FSM: standard 1149.1 transitions on TMS at posedge C.
- Five consecutive TMS=1 clocks reach Test-Logic-Reset from any state.
- Encoding:
  - 0 TLR, 1 RTI
  - 2 SelDR, 3 CapDR, 4 ShDR, 5 Ex1DR, 6 PauseDR, 7 Ex2DR, 8 UpdDR
  - 9 SelIR, 10 CapIR, 11 ShIR, 12 Ex1IR, 13 PauseIR, 14 Ex2IR, 15 UpdIR
- While in TLR, IR is held at OP_IDCODE (synchronous).
- Capture-IR: IR shift ← {0...,2'b01}.
- Shift-IR: shift right, TDI→MSB, TDO=LSB.
- Update-IR: IR ← IR shift. Any opcode other than IDCODE or SAMPLE selects BYPASS.
- Capture-DR by selected DR:
  - IDCODE: 32-bit shift ← IDCODE.
  - BYPASS: 1-bit reg ← 0.
  - SAMPLE: shift ← SAMPLE_IN.
- Shift-DR: selected register shifts right, TDI→MSB, TDO=LSB of the selected register. Latency TDI→TDO = register length in clocks (BYPASS: 1).
- Update-DR under SAMPLE: SAMPLE_OUT ← sample shift, and UPDATE_STB=1 for exactly that one cycle. No effect under other instructions.
- Pause states hold shift contents; Exit2→Shift resumes without re-capture.
- Capture followed by Exit1 with zero shifts is legal.
- Outside Shift states: TDO=0, TDO_OE=0.
- TDO is combinational from the state register and the shift LSB. TDO is stable after posedge C and before the next posedge (initiator samples it on the following posedge).
- IR or DR shifted longer than its length: excess bits fall off the LSB. The final contents are the last N TDI bits.

Test Plan:
1. Async reset: assert CLR_N low mid-Shift-DR → TAP_STATE=0, TDO_OE=0. Then RTI→SelDR→CapDR→32×ShDR → TDO sequence LSB-first = 32'h06E1C093 (default IR is IDCODE, no IR load needed).
2. IR capture: shift 8 bits 8'hFF into IR → TDO during ShIR reads 1,0,0,0,0,0,0,0. Then UpdIR and shift DR 0,1,1,0 → TDO 0 (captured), 0,1,1 (1-cycle BYPASS delay).
3. SAMPLE: load IR 8'h03, SAMPLE_IN=32'hA5A5_0F0F, CapDR, shift 32 bits TDI=32'h1234_5678 → TDO yields 32'hA5A50F0F LSB-first. At UpdDR, SAMPLE_OUT=32'h12345678 and UPDATE_STB high for exactly one clock.
4. Pause/resume under SAMPLE: shift 10 bits, Ex1→Pause (hold 5 clocks)→Ex2→ShDR for 22 more bits → result identical to scenario 3. TDO_OE low during Pause.
5. Unknown opcode 8'h5A → behaves as BYPASS (1-bit path, leading TDO 0). UpdDR leaves SAMPLE_OUT unchanged and UPDATE_STB stays 0.
6. TMS=1 for 5 clocks from ShIR, PauseDR and UpdIR each → TAP_STATE=0 and IR=8'h01.
